// File: rtl/feature_window_packer.sv
// Serial-to-parallel packer: assembles N_FEAT-entry feature vectors (entry 0 = bias)
// from a sample stream, double-buffered behind a registered valid/ready output.
// Optional macro FRAME_COUNT_EN adds a 16-bit count of emitted vectors (frame_cnt).
module feature_window_packer #(
  parameter int unsigned  N_FEAT   = 41,
  parameter int unsigned  W        = 32,
  parameter logic [W-1:0] BIAS_VAL = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         s_last,
  output logic [W-1:0] xarray [0:N_FEAT-1],
  output logic         m_valid,
  input  logic         m_ready,
  output logic         err
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0]  frame_cnt
`endif
);

  localparam int unsigned  CW        = $clog2(N_FEAT);
  localparam logic [CW-1:0] LAST_SLOT = CW'(N_FEAT - 2);

  typedef enum logic [0:0] {ST_FILL, ST_WAIT} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  fbuf  [1:N_FEAT-1];
  logic [W-1:0]  vec_c [1:N_FEAT-1];
  logic          accept, drain, at_end;
  logic          load_in, load_buf, park, write_slot;
  logic          err_d, ready_d, mvalid_d;

  // Vector as it stands if completed now: held slots, current sample, zero padding.
  always_comb begin
    for (int k = 1; k < int'(N_FEAT); k++) begin
      if (CW'(k) <= cnt)                vec_c[k] = fbuf[k];
      else if (CW'(k) == cnt + CW'(1))  vec_c[k] = s_data;
      else                              vec_c[k] = '0;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    load_in    = 1'b0;
    load_buf   = 1'b0;
    park       = 1'b0;
    write_slot = 1'b0;
    err_d      = 1'b0;
    accept     = s_valid & s_ready;
    drain      = m_valid & m_ready;
    at_end     = (cnt == LAST_SLOT);
    mvalid_d   = m_valid & ~drain;
    case (state)
      ST_FILL: begin
        if (accept) begin
          // Framing error: early s_last, or the final slot filled without s_last.
          err_d = s_last ^ at_end;
          if (s_last || at_end) begin
            cnt_d = '0;
            if (!m_valid || m_ready) begin
              load_in  = 1'b1;
              mvalid_d = 1'b1;
            end else begin
              park    = 1'b1;
              state_d = ST_WAIT;
            end
          end else begin
            write_slot = 1'b1;
            cnt_d      = cnt + CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (drain) begin
          load_buf = 1'b1;
          mvalid_d = 1'b1;
          state_d  = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
    ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FILL;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      err     <= 1'b0;
      for (int k = 0; k < int'(N_FEAT); k++) xarray[k] <= '0;
      for (int k = 1; k < int'(N_FEAT); k++) fbuf[k] <= '0;
    end else begin
      cnt     <= cnt_d;
      s_ready <= ready_d;
      m_valid <= mvalid_d;
      err     <= err_d;
      if (write_slot) fbuf[cnt + CW'(1)] <= s_data;
      if (park) begin
        for (int k = 1; k < int'(N_FEAT); k++) fbuf[k] <= vec_c[k];
      end
      // Output register loads straight from the input path or from the parked vector.
      if (load_in) begin
        xarray[0] <= BIAS_VAL;
        for (int k = 1; k < int'(N_FEAT); k++) xarray[k] <= vec_c[k];
      end else if (load_buf) begin
        xarray[0] <= BIAS_VAL;
        for (int k = 1; k < int'(N_FEAT); k++) xarray[k] <= fbuf[k];
      end
    end
  end

`ifdef FRAME_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    frame_cnt <= '0;
    else if (m_valid & m_ready) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_feature_window_packer.sv
// Bench for feature_window_packer: directed scenarios plus a randomized stream
// checked against a queue-based vector model.
module tb_feature_window_packer;

  localparam int unsigned N = 41;
  localparam int unsigned W = 32;
  typedef logic [N*W-1:0] flat_t;

  logic         clk = 1'b0;
  logic         rst, s_valid, s_ready, s_last, m_valid, m_ready, err;
  logic [W-1:0] s_data;
  logic [W-1:0] xarray [0:N-1];
`ifdef FRAME_COUNT_EN
  logic [15:0]  frame_cnt;
`endif

  always #5 clk = ~clk;

  feature_window_packer #(.N_FEAT(N), .W(W), .BIAS_VAL(32'd1)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .xarray(xarray), .m_valid(m_valid), .m_ready(m_ready), .err(err)
`ifdef FRAME_COUNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  int    n_pass = 0, n_total = 0;
  int    err_cycles = 0, hold_viol = 0;
  bit    rec_en = 1'b1;
  bit    pend = 1'b0;
  flat_t held;
  flat_t got_q[$];

  function automatic flat_t pack_x();
    flat_t f;
    for (int k = 0; k < int'(N); k++) f[k*W +: W] = xarray[k];
    return f;
  endfunction

  // Expected vector: bias, the samples in order, zeros after.
  function automatic flat_t model_vec(input logic [W-1:0] samp [$]);
    flat_t f = '0;
    f[0 +: W] = 32'd1;
    for (int i = 0; i < samp.size(); i++) f[(i+1)*W +: W] = samp[i];
    return f;
  endfunction

  function automatic int first_diff(input flat_t a, input flat_t b);
    for (int k = 0; k < int'(N); k++) if (a[k*W +: W] !== b[k*W +: W]) return k;
    return -1;
  endfunction

  function automatic logic [W-1:0] entry(input flat_t f, input int k);
    return f[k*W +: W];
  endfunction

  // Observer: err cycles, transfers, and output stability while stalled.
  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    else begin
      if (err) err_cycles++;
      if (pend && (!m_valid || pack_x() !== held)) hold_viol++;
      pend = m_valid && !m_ready;
      held = pack_x();
      if (rec_en && m_valid && m_ready) got_q.push_back(pack_x());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, output bit ok);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && t < 300) begin step(); t++; end
    ok = s_ready;
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    flat_t z = '0;
    int d;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) step();
    n_total++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    d = first_diff(pack_x(), z);
    n_total++; if (d >= 0) $display("FAIL rst_xarray: entry %0d got %h want 0", d, entry(pack_x(), d)); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready: got %b want 1", s_ready); else n_pass++;
  endtask

  task automatic test_full();
    logic [W-1:0] samp[$];
    bit ok, all_ok = 1'b1;
    int e0 = err_cycles, d;
    flat_t e;
    m_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      send(W'(k), k == 40, ok);
      all_ok &= ok;
      samp.push_back(W'(k));
      if (k == 39) begin
        n_total++; if (m_valid !== 1'b0) $display("FAIL full_mvalid_early: got %b want 0", m_valid); else n_pass++;
      end
    end
    n_total++; if (!all_ok) $display("FAIL full_accept: got timeout want accepted"); else n_pass++;
    n_total++; if (m_valid !== 1'b1) $display("FAIL full_mvalid: got %b want 1", m_valid); else n_pass++;
    e = model_vec(samp);
    d = first_diff(pack_x(), e);
    n_total++; if (d >= 0) $display("FAIL full_xarray: entry %0d got %h want %h", d, entry(pack_x(), d), entry(e, d)); else n_pass++;
    step();
    n_total++; if (m_valid !== 1'b0) $display("FAIL full_drain: got %b want 0", m_valid); else n_pass++;
    step();
    n_total++; if (err_cycles - e0 != 0) $display("FAIL full_err: got %0d want 0", err_cycles - e0); else n_pass++;
  endtask

  task automatic test_early();
    logic [W-1:0] samp[$];
    bit ok;
    int e0 = err_cycles, d;
    flat_t e;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(W'(100 + i), i == 9, ok);
      samp.push_back(W'(100 + i));
    end
    n_total++; if (err !== 1'b1) $display("FAIL early_err_pulse: got %b want 1", err); else n_pass++;
    e = model_vec(samp);
    d = first_diff(pack_x(), e);
    n_total++; if (d >= 0) $display("FAIL early_xarray: entry %0d got %h want %h", d, entry(pack_x(), d), entry(e, d)); else n_pass++;
    step();
    n_total++; if (err !== 1'b0) $display("FAIL early_err_end: got %b want 0", err); else n_pass++;
    n_total++; if (err_cycles - e0 != 1) $display("FAIL early_err_len: got %0d want 1", err_cycles - e0); else n_pass++;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_total++; if (m_valid !== 1'b0) $display("FAIL early_drain: got %b want 0", m_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sa[$], sb[$];
    bit ok, all_ok = 1'b1;
    int d, e0 = err_cycles, h0 = hold_viol;
    flat_t ea, eb;
    m_ready = 1'b0;
    for (int k = 1; k <= 40; k++) begin send(W'(k), k == 40, ok); all_ok &= ok; sa.push_back(W'(k)); end
    for (int k = 1; k <= 40; k++) begin send(W'(k + 1000), k == 40, ok); all_ok &= ok; sb.push_back(W'(k + 1000)); end
    ea = model_vec(sa);
    eb = model_vec(sb);
    n_total++; if (!all_ok) $display("FAIL bp_accept: got timeout want accepted"); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_low: got %b want 0", s_ready); else n_pass++;
    d = first_diff(pack_x(), ea);
    n_total++; if (d >= 0) $display("FAIL bp_hold_a: entry %0d got %h want %h", d, entry(pack_x(), d), entry(ea, d)); else n_pass++;
    // A sample offered while stalled must be ignored.
    s_valid = 1'b1; s_data = 32'hdead_beef; s_last = 1'b1;
    repeat (3) step();
    s_valid = 1'b0; s_last = 1'b0;
    n_total++; if (s_ready !== 1'b0) $display("FAIL bp_stall_s_ready: got %b want 0", s_ready); else n_pass++;
    m_ready = 1'b1;
    step();
    n_total++; if (m_valid !== 1'b1) $display("FAIL bp_no_bubble: got %b want 1", m_valid); else n_pass++;
    d = first_diff(pack_x(), eb);
    n_total++; if (d >= 0) $display("FAIL bp_load_b: entry %0d got %h want %h", d, entry(pack_x(), d), entry(eb, d)); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL bp_s_ready_back: got %b want 1", s_ready); else n_pass++;
    step();
    m_ready = 1'b0;
    n_total++; if (m_valid !== 1'b0) $display("FAIL bp_final_drain: got %b want 0", m_valid); else n_pass++;
    d = first_diff(pack_x(), eb);
    n_total++; if (d >= 0) $display("FAIL bp_keep_b: entry %0d got %h want %h", d, entry(pack_x(), d), entry(eb, d)); else n_pass++;
    n_total++; if (hold_viol != h0) $display("FAIL bp_stable: got %0d violations want 0", hold_viol - h0); else n_pass++;
    n_total++; if (err_cycles != e0) $display("FAIL bp_err: got %0d want 0", err_cycles - e0); else n_pass++;
  endtask

  task automatic test_missing_last();
    logic [W-1:0] s1[$], s2[$];
    bit ok;
    int d, e0 = err_cycles;
    flat_t e1, e2, g;
    got_q.delete();
    m_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin send(W'(200 + k), 1'b0, ok); s1.push_back(W'(200 + k)); end
    e1 = model_vec(s1);
    n_total++; if (err !== 1'b1) $display("FAIL nolast_err: got %b want 1", err); else n_pass++;
    n_total++; if (m_valid !== 1'b1) $display("FAIL nolast_mvalid: got %b want 1", m_valid); else n_pass++;
    d = first_diff(pack_x(), e1);
    n_total++; if (d >= 0) $display("FAIL nolast_xarray: entry %0d got %h want %h", d, entry(pack_x(), d), entry(e1, d)); else n_pass++;
    for (int k = 1; k <= 40; k++) begin send(W'(300 + k), k == 40, ok); s2.push_back(W'(300 + k)); end
    e2 = model_vec(s2);
    repeat (3) step();
    n_total++; if (got_q.size() != 2) $display("FAIL nolast_count: got %0d want 2", got_q.size()); else n_pass++;
    if (got_q.size() >= 2) begin
      g = got_q[1];
      d = first_diff(g, e2);
      n_total++; if (d >= 0) $display("FAIL nolast_second: entry %0d got %h want %h", d, entry(g, d), entry(e2, d)); else n_pass++;
    end
    n_total++; if (err_cycles - e0 != 1) $display("FAIL nolast_err_count: got %0d want 1", err_cycles - e0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] samp[$];
    bit ok;
    int d, e0;
    flat_t z = '0, e;
    m_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin send(W'(400 + k), 1'b0, ok); end
    rst = 1'b1;
    #1;
    n_total++; if (m_valid !== 1'b0) $display("FAIL rstmid_mvalid: got %b want 0", m_valid); else n_pass++;
    d = first_diff(pack_x(), z);
    n_total++; if (d >= 0) $display("FAIL rstmid_xarray: entry %0d got %h want 0", d, entry(pack_x(), d)); else n_pass++;
    step();
    rst = 1'b0;
    e0 = err_cycles;
    step();
    for (int k = 1; k <= 40; k++) begin
      send(W'(500 + k), k == 40, ok);
      samp.push_back(W'(500 + k));
      if (k == 39) begin
        n_total++; if (m_valid !== 1'b0) $display("FAIL rstmid_no_stale: got %b want 0", m_valid); else n_pass++;
      end
    end
    e = model_vec(samp);
    d = first_diff(pack_x(), e);
    n_total++; if (d >= 0) $display("FAIL rstmid_clean: entry %0d got %h want %h", d, entry(pack_x(), d), entry(e, d)); else n_pass++;
    repeat (2) step();
    n_total++; if (err_cycles != e0) $display("FAIL rstmid_err: got %0d want 0", err_cycles - e0); else n_pass++;
  endtask

  task automatic test_random();
    flat_t exp_q[$];
    int exp_err = 0, e0 = err_cycles, h0 = hold_viol, bad = 0, t = 0;
    bit done = 1'b0, all_ok = 1'b1;
    got_q.delete();
    fork
      begin
        for (int v = 0; v < 25; v++) begin
          logic [W-1:0] samp[$];
          int len = $urandom_range(1, 40);
          bit lastf = (len < 40) ? 1'b1 : 1'($urandom_range(0, 1));
          bit ok;
          for (int i = 0; i < len; i++) begin
            logic [W-1:0] x = $urandom;
            repeat ($urandom_range(0, 2)) step();
            send(x, (i == len - 1) && lastf, ok);
            all_ok &= ok;
            samp.push_back(x);
          end
          exp_q.push_back(model_vec(samp));
          if (len < 40 || !lastf) exp_err++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          if (!done) m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    while (got_q.size() < exp_q.size() && t < 100) begin step(); t++; end
    repeat (2) step();
    n_total++; if (!all_ok) $display("FAIL rand_accept: got timeout want accepted"); else n_pass++;
    n_total++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    n_total++; if (bad != 0) $display("FAIL rand_vectors: got %0d wrong vectors want 0", bad); else n_pass++;
    n_total++; if (err_cycles - e0 != exp_err) $display("FAIL rand_err: got %0d want %0d", err_cycles - e0, exp_err); else n_pass++;
    n_total++; if (hold_viol != h0) $display("FAIL rand_stable: got %0d violations want 0", hold_viol - h0); else n_pass++;
  endtask

`ifdef FRAME_COUNT_EN
  task automatic test_frame_count();
    rec_en = 1'b0;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_total++; if (frame_cnt !== 16'd0) $display("FAIL fc_reset: got %0d want 0", frame_cnt); else n_pass++;
    s_valid = 1'b1; s_last = 1'b1; s_data = 32'h5;
    repeat (3) step();
    s_valid = 1'b0;
    step();
    n_total++; if (frame_cnt !== 16'd3) $display("FAIL fc_three: got %0d want 3", frame_cnt); else n_pass++;
    s_valid = 1'b1;
    repeat (65532) step();
    s_valid = 1'b0;
    step();
    n_total++; if (frame_cnt !== 16'd65535) $display("FAIL fc_max: got %0d want 65535", frame_cnt); else n_pass++;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    s_last = 1'b0;
    n_total++; if (frame_cnt !== 16'd0) $display("FAIL fc_wrap: got %0d want 0", frame_cnt); else n_pass++;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full();
    test_early();
    test_back_to_back();
    test_missing_last();
    test_reset_mid();
    test_random();
`ifdef FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
